// File: rtl/control_sequencer.sv
// Hardwired control unit for the phase-1 datapath: fetch (T0-T2) and execute (T3-T6)
// for R-format ALU ops, MUL/DIV via HI/LO, NOP and HALT, with a T1 memory-wait timeout.
module control_sequencer #(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [31:0]      IR,
    input  logic             Mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [OPC_W-1:0] alu_op,
    output logic             Run,
    output logic             Illegal,
    output logic             Mem_err
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] T1_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [OPC_W-1:0] OP_ALU_MAX = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_MUL     = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_DIV     = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_NOP     = OPC_W'(26);
    localparam logic [OPC_W-1:0] OP_HALT    = OPC_W'(27);

    state_t           state;
    logic [CW-1:0]    t1_cnt;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] opc;
    logic             is_exec;
    logic             is_halt;
    logic             is_illegal;
    logic             q_muldiv;
    logic             unused_ir;

    assign opc        = IR[31 -: OPC_W];
    assign unused_ir  = ^IR[31-OPC_W:0];
    assign is_exec    = (opc <= OP_ALU_MAX) || (opc == OP_MUL) || (opc == OP_DIV);
    assign is_halt    = (opc == OP_HALT);
    assign is_illegal = !is_exec && !is_halt && (opc != OP_NOP);
    assign q_muldiv   = (opc_q == OP_MUL) || (opc_q == OP_DIV);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_RESET;
            t1_cnt  <= '0;
            opc_q   <= '0;
            Mem_err <= 1'b0;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0: begin
                    t1_cnt <= '0;
                    state  <= Stop ? S_HALT : S_T1;
                end
                S_T1: begin
                    if (Mem_ready) begin
                        state <= S_T2;
                    end else if (MEM_TIMEOUT > 0 && t1_cnt == T1_LAST) begin
                        Mem_err <= 1'b1;
                        state   <= S_HALT;
                    end else if (t1_cnt != '1) begin
                        // saturates so PCin stays low when the timeout is disabled
                        t1_cnt <= t1_cnt + CW'(1);
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    opc_q <= opc;
                    if (is_exec)      state <= S_T4;
                    else if (is_halt) state <= S_HALT;
                    else              state <= S_T0;
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= q_muldiv ? S_T6 : S_T0;
                S_T6:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    // T3 strobes read IR directly: it is only loaded on the T2->T3 edge
    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout}                 = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin}   = '0;
        {IncPC, Read, Gra, Grb, Grc, Rin, Rout, Illegal}   = '0;
        alu_op = '0;
        Run    = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: {PCout, MARin, IncPC, Zin} = '1;
            S_T1: begin
                {Zlowout, Read, MDRin} = '1;
                PCin = (t1_cnt == '0);
            end
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                {Grb, Rout, Yin} = {3{is_exec}};
                Illegal = is_illegal;
            end
            S_T4: begin
                {Grc, Rout, Zin} = '1;
                alu_op = opc_q;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = q_muldiv;
                Gra     = !q_muldiv;
                Rin     = !q_muldiv;
            end
            S_T6: {Zhighout, HIin} = '1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: an instruction-level model expands each instruction
// into per-cycle expected strobe sets; a negedge monitor compares them against the DUT.
module tb_control_sequencer;

    typedef struct packed {
        logic PCout, Zhighout, Zlowout, MDRout;
        logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
        logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
        logic [4:0] alu_op;
        logic Run, Illegal, Mem_err;
    } outs_t;

    localparam int C_ALU = 0, C_MULDIV = 1, C_NOP = 2, C_HALT = 3, C_ILL = 4;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] IR = '0;
    logic        Mem_ready = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal, Mem_err;
    logic [4:0] alu_op;

    outs_t act;
    outs_t mon_e;
    outs_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cycle = 0;

    control_sequencer #(.OPC_W(5), .MEM_TIMEOUT(15)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run),
        .Illegal(Illegal), .Mem_err(Mem_err)
    );

    assign act = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op,
                  Run, Illegal, Mem_err};

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        cycle++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (act !== mon_e) begin
                bad++;
                $display("FAIL outputs cycle=%0d actual=%h required=%h", cycle, act, mon_e);
            end
            total++;
            if ($countones({PCout, Zhighout, Zlowout, MDRout, Rout}) > 1) begin
                bad++;
                $display("FAIL bus_onehot cycle=%0d actual=%b required=at most one high",
                         cycle, {PCout, Zhighout, Zlowout, MDRout, Rout});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int cls(input logic [4:0] op);
        if (op <= 5'd11) return C_ALU;
        if (op == 5'd15 || op == 5'd16) return C_MULDIV;
        if (op == 5'd26) return C_NOP;
        if (op == 5'd27) return C_HALT;
        return C_ILL;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t run_e();
        outs_t e = '0;
        e.Run = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] rand_ir();
        int unsigned r = $urandom_range(0, 19);
        logic [4:0] op;
        if (r <= 7 || r >= 18) op = 5'($urandom_range(0, 11));
        else if (r <= 11)      op = (r[0]) ? 5'd15 : 5'd16;
        else if (r <= 13)      op = 5'd26;
        else if (r == 17)      op = 5'd27;
        else begin
            op = 5'd12;
            for (int k = 0; k < 64; k++) begin
                op = 5'($urandom_range(0, 31));
                if (cls(op) == C_ILL) break;
            end
            if (cls(op) != C_ILL) op = 5'd12;
        end
        return {op, 27'($urandom)};
    endfunction

    task automatic cyc(input outs_t e, input logic rn, input logic mr, input logic st,
                       input logic [31:0] ir);
        @(posedge Clock);
        #1;
        Reset_n = rn; Mem_ready = mr; Stop = st; IR = ir;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc('0, 1'b0, rb(), rb(), $urandom);
        cyc('0, 1'b1, rb(), rb(), $urandom);
    endtask

    task automatic halt_tail(input logic merr);
        outs_t e = '0;
        e.Mem_err = merr;
        for (int unsigned i = 0; i < $urandom_range(2, 5); i++) cyc(e, 1'b1, rb(), rb(), $urandom);
        do_reset($urandom_range(1, 3));
    endtask

    // waits >= 15 means Mem_ready never arrives
    task automatic run_instr(input logic [31:0] ir, input int unsigned waits,
                             input logic stop, input logic abort_t4);
        outs_t e;
        int    c = cls(ir[31:27]);
        logic  tmo = (waits >= 15);
        e = run_e(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
        cyc(e, 1'b1, rb(), stop, $urandom);
        if (stop) begin halt_tail(1'b0); return; end
        for (int unsigned i = 0; i < (tmo ? 15 : waits + 1); i++) begin
            e = run_e(); e.Zlowout = 1; e.Read = 1; e.MDRin = 1; e.PCin = (i == 0);
            cyc(e, 1'b1, (!tmo && i == waits), rb(), $urandom);
        end
        if (tmo) begin halt_tail(1'b1); return; end
        e = run_e(); e.MDRout = 1; e.IRin = 1;
        cyc(e, 1'b1, rb(), rb(), ir);
        e = run_e();
        if (c == C_ALU || c == C_MULDIV) begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
        if (c == C_ILL) e.Illegal = 1;
        cyc(e, 1'b1, rb(), rb(), ir);
        if (c == C_HALT) begin halt_tail(1'b0); return; end
        if (c == C_NOP || c == C_ILL) return;
        if (abort_t4) begin do_reset($urandom_range(1, 3)); return; end
        e = run_e(); e.Grc = 1; e.Rout = 1; e.Zin = 1; e.alu_op = ir[31:27];
        cyc(e, 1'b1, rb(), rb(), ir);
        e = run_e(); e.Zlowout = 1;
        if (c == C_MULDIV) e.LOin = 1;
        else begin e.Gra = 1; e.Rin = 1; end
        cyc(e, 1'b1, rb(), rb(), ir);
        if (c == C_MULDIV) begin
            e = run_e(); e.Zhighout = 1; e.HIin = 1;
            cyc(e, 1'b1, rb(), rb(), ir);
        end
    endtask

    initial begin
        logic [31:0] ir;
        int unsigned w;
        do_reset(2);
        run_instr(32'h4A92_0000, 0, 1'b0, 1'b0);
        run_instr({5'd3, 27'h123_4567}, 3, 1'b0, 1'b0);
        run_instr({5'b01111, 27'h0AB_CDEF}, 1, 1'b0, 1'b0);
        run_instr({5'b10000, 27'h055_5555}, 0, 1'b0, 1'b0);
        run_instr({5'b01100, 27'h000_0000}, 0, 1'b0, 1'b0);
        run_instr({5'b11010, 27'h000_0000}, 2, 1'b0, 1'b0);
        run_instr({5'd1, 27'h000_0042}, 0, 1'b0, 1'b1);
        run_instr({5'd2, 27'h000_0000}, 0, 1'b1, 1'b0);
        run_instr({5'b11011, 27'h000_0000}, 1, 1'b0, 1'b0);
        run_instr({5'd4, 27'h000_0000}, 15, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            ir = rand_ir();
            w  = ($urandom_range(0, 39) == 0) ? 15 : $urandom_range(0, 3);
            run_instr(ir, w, ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0));
        end
        @(posedge Clock);
        @(posedge Clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
